// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction RAM with registered fetch, flush, stall and range fault
module imem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              branch,
  input  logic              stall,
  output logic [DATA_W-1:0] instruction,
  output logic              valid,
  output logic              fault,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [ADDR_W:0] DMAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH);
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] cnt, len, len_in;
  logic we, last, in_range;
  always_comb begin
    len_in = load_len > DMAX ? DMAX : load_len;
    we = load_valid && load_ready;
    last = we && cnt == len - ONE;
    in_range = pc < DEPTH32;
  end
  always_ff @(posedge clk)
    if (we) mem[cnt[ADDR_W-1:0]] <= load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      instruction <= NOP;
      valid <= 1'b0;
      fault <= 1'b0;
      load_ready <= 1'b0;
      load_done <= 1'b0;
      cnt <= '0;
      len <= '0;
    end else begin
      load_done <= 1'b0;
      // a zero-length load keeps ready low so nothing can be written
      if (state != LOAD && load_start) begin
        state <= LOAD;
        cnt <= '0;
        len <= len_in;
        load_ready <= len_in != '0;
      end else if (state == LOAD && (len == '0 || last)) begin
        state <= RUN;
        load_ready <= 1'b0;
        load_done <= 1'b1;
      end else if (we) begin
        cnt <= cnt + ONE;
      end
      if (branch || state != RUN) begin
        instruction <= NOP;
        valid <= 1'b0;
        fault <= 1'b0;
      end else if (!stall) begin
        instruction <= in_range ? mem[pc[ADDR_W-1:0]] : NOP;
        valid <= in_range;
        fault <= !in_range;
      end
    end
  end
endmodule
